ready_skid_beats: RTL and testbench

- Ready-path register slice for the valid/ready beat interface. It is the counterpart of the forward (valid/data) register slice.
- Registers the backpressure path: ready_in is driven from a flop, never combinationally from ready_out.
- A single-entry skid buffer absorbs the one beat already accepted when downstream deasserts ready_out.
- Valid and data pass forward with zero latency when the skid buffer is empty. The slice sits between pipeline stages where ready fan-in or timing on the ready path is critical.

---
 rtl/ready_skid_beats.sv | 91 +++++++++
 tb/tb_ready_skid_beats.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ready_skid_beats.sv
// Ready-path register slice: ready_in comes from a flop, and a one-entry skid buffer
// absorbs the beat accepted as downstream stalls. Optional beat counter: READY_SKID_BEAT_CNT_EN.
module ready_skid_beats #(
  parameter int unsigned DATA_WD = 8,
  parameter int unsigned CNT_WD  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  input  logic [DATA_WD-1:0] data_in,
  output logic               ready_in,
  output logic               valid_out,
  output logic [DATA_WD-1:0] data_out,
  input  logic               ready_out
`ifdef READY_SKID_BEAT_CNT_EN
  ,
  output logic [CNT_WD-1:0]  beat_cnt
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt;
  logic               skid_valid_r;
  logic [DATA_WD-1:0] skid_data_r;
  logic               capture;

  if (CNT_WD < 1 || DATA_WD < 1) begin : g_param_check
    $error("ready_skid_beats: DATA_WD and CNT_WD must be at least 1");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt;
    end
  end

  // The skid register is written only when a beat is accepted but cannot be delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_data_r <= '0;
    end else if (capture) begin
      skid_data_r <= data_in;
    end
  end

  always_comb begin
    state_nxt = state_r;
    capture   = 1'b0;
    case (state_r)
      EMPTY: begin
        if (valid_in && !ready_out) begin
          capture   = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (ready_out) begin
          state_nxt = EMPTY;
        end
      end
    endcase
  end

  // Upstream ready depends only on the state flop, never on ready_out.
  assign skid_valid_r = (state_r == FULL);
  assign ready_in     = ~skid_valid_r;
  assign valid_out    = skid_valid_r | valid_in;
  assign data_out     = skid_valid_r ? skid_data_r : data_in;

`ifdef READY_SKID_BEAT_CNT_EN
  logic fire_out;
  assign fire_out = valid_out & ready_out;

  // Free-running count of delivered beats, wrapping modulo 2^CNT_WD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (fire_out) begin
      beat_cnt <= beat_cnt + CNT_WD'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ready_skid_beats.sv
// Directed and scoreboard-checked bench for ready_skid_beats; the counter section
// is compiled only with READY_SKID_BEAT_CNT_EN.
module tb_ready_skid_beats;

  localparam int unsigned DATA_WD = 8;
  localparam int unsigned CNT_WD  = 4;

  logic               clk;
  logic               rst_n;
  logic               valid_in;
  logic [DATA_WD-1:0] data_in;
  logic               ready_in;
  logic               valid_out;
  logic [DATA_WD-1:0] data_out;
  logic               ready_out;
`ifdef READY_SKID_BEAT_CNT_EN
  logic [CNT_WD-1:0]  beat_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  ready_skid_beats #(
    .DATA_WD (DATA_WD),
    .CNT_WD  (CNT_WD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .ready_out (ready_out)
`ifdef READY_SKID_BEAT_CNT_EN
    ,
    .beat_cnt  (beat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [DATA_WD-1:0] sb_q[$];
    logic [DATA_WD-1:0] next_in;
    logic [DATA_WD-1:0] exp_d;
    logic               last_fin;
    logic               fin;
    logic               fout;

    rst_n     = 1'b0;
    valid_in  = 1'b0;
    data_in   = '0;
    ready_out = 1'b1;
    #1;
    chk("rst_ready_in", 32'(ready_in), 32'd1);
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Pass-through with downstream always ready.
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      valid_in  = 1'b1;
      data_in   = DATA_WD'(8'h11 * i);
      ready_out = 1'b1;
      #1;
      chk("pt_ready_in", 32'(ready_in), 32'd1);
      chk("pt_valid_out", 32'(valid_out), 32'd1);
      chk("pt_data_out", 32'(data_out), 32'(8'h11 * i));
    end

    // Stall: A5 accepted while ready_out low, goes into the skid buffer.
    @(negedge clk);
    valid_in  = 1'b1;
    data_in   = 8'hA5;
    ready_out = 1'b0;
    #1;
    chk("stall_accept_ready_in", 32'(ready_in), 32'd1);
    chk("stall_accept_data_out", 32'(data_out), 32'hA5);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      data_in = 8'h5A;
      #1;
      chk("full_ready_in", 32'(ready_in), 32'd0);
      chk("full_valid_out", 32'(valid_out), 32'd1);
      chk("full_data_out", 32'(data_out), 32'hA5);
    end
    // ready_out rises mid-cycle: ready_in must not follow combinationally.
    #1 ready_out = 1'b1;
    #1;
    chk("no_comb_ready", 32'(ready_in), 32'd0);
    chk("full_deliver_data", 32'(data_out), 32'hA5);
    @(negedge clk);
    #1;
    chk("drain_ready_in", 32'(ready_in), 32'd1);
    chk("drain_next_data", 32'(data_out), 32'h5A);
    chk("drain_valid_out", 32'(valid_out), 32'd1);
    @(negedge clk);
    valid_in  = 1'b0;
    ready_out = 1'b0;
    #1;
    chk("idle_ready_in", 32'(ready_in), 32'd1);
    chk("idle_valid_out", 32'(valid_out), 32'd0);

    // Asynchronous reset while FULL with 3C.
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = 8'h3C;
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    chk("pre_rst_valid_out", 32'(valid_out), 32'd1);
    chk("pre_rst_data_out", 32'(data_out), 32'h3C);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid_out", 32'(valid_out), 32'd0);
    chk("async_rst_ready_in", 32'(ready_in), 32'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    ready_out = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_valid_out", 32'(valid_out), 32'd0);
    end

    // Random valid/ready with incrementing payload against an in-order scoreboard.
    next_in  = '0;
    last_fin = 1'b0;
    valid_in = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!valid_in || last_fin) begin
        valid_in = 1'($urandom_range(0, 1));
        data_in  = next_in;
      end
      ready_out = 1'($urandom_range(0, 1));
      #1;
      fin  = valid_in & ready_in;
      fout = valid_out & ready_out;
      if (fin) begin
        sb_q.push_back(data_in);
        next_in = next_in + DATA_WD'(1);
      end
      if (fout) begin
        if (sb_q.size() == 0) begin
          chk("rand_unexpected_beat", 32'd1, 32'd0);
        end else begin
          exp_d = sb_q.pop_front();
          chk("rand_order", 32'(data_out), 32'(exp_d));
        end
      end
      last_fin = fin;
    end
    @(negedge clk);
    if (valid_in && !last_fin) begin
      valid_in = 1'b1;
    end else begin
      valid_in = 1'b0;
    end
    ready_out = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      fin  = valid_in & ready_in;
      fout = valid_out & ready_out;
      if (fin) sb_q.push_back(data_in);
      if (fout) begin
        if (sb_q.size() == 0) begin
          chk("drain_unexpected_beat", 32'd1, 32'd0);
        end else begin
          exp_d = sb_q.pop_front();
          chk("drain_order", 32'(data_out), 32'(exp_d));
        end
      end
      @(negedge clk);
      if (fin) valid_in = 1'b0;
    end
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

`ifdef READY_SKID_BEAT_CNT_EN
    // Counter wraps modulo 16 after 17 delivered beats.
    valid_in = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("cnt_reset", 32'(beat_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("cnt_after_reset", 32'(beat_cnt), 32'd0);
    valid_in  = 1'b1;
    ready_out = 1'b1;
    repeat (17) @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    chk("cnt_wrap", 32'(beat_cnt), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
